// File: rtl/asic_tap_pkg.sv
// Shared types and constants for the adder-with-TAP block: controller state
// encoding, instruction opcodes, default widths and the IR capture pattern.
`timescale 1ns/1ps
package asic_tap_pkg;

  localparam int unsigned DEF_SIZE     = 4;
  localparam int unsigned DEF_BSR_SIZE = 2*DEF_SIZE + 1 + DEF_SIZE + 1;
  localparam int unsigned DEF_IR_SIZE  = 3;

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
  } tap_state_t;

  localparam logic [DEF_IR_SIZE-1:0] OP_BYPASS         = 3'b111;
  localparam logic [DEF_IR_SIZE-1:0] OP_EXTEST         = 3'b001;
  localparam logic [DEF_IR_SIZE-1:0] OP_SAMPLE_PRELOAD = 3'b010;
  localparam logic [DEF_IR_SIZE-1:0] OP_INTEST         = 3'b011;
  localparam logic [DEF_IR_SIZE-1:0] OP_RUNBIST        = 3'b100;
  localparam logic [DEF_IR_SIZE-1:0] OP_IDCODE         = 3'b101;
  localparam logic [DEF_IR_SIZE-1:0] IR_CAPTURE        = 3'b001;

  // Only the three boundary instructions route the BSR between TDI and TDO;
  // every other code (RUNBIST, IDCODE, undefined) falls back to bypass.
  function automatic logic selects_bsr(input logic [DEF_IR_SIZE-1:0] op);
    return op inside {OP_EXTEST, OP_SAMPLE_PRELOAD, OP_INTEST};
  endfunction

endpackage

// File: rtl/asic_with_tap_if.sv
// Pad and serial test signals of the adder-with-TAP chip, grouped as one bundle.
`timescale 1ns/1ps
interface asic_with_tap_if #(parameter int unsigned SIZE = asic_tap_pkg::DEF_SIZE);
  logic [SIZE-1:0] a;
  logic [SIZE-1:0] b;
  logic            c_in;
  logic [SIZE-1:0] sum;
  logic            c_out;
  logic            TDI;
  logic            TMS;
  logic            TDO;

  modport master (output a, b, c_in, TDI, TMS, input sum, c_out, TDO);
  modport slave  (input a, b, c_in, TDI, TMS, output sum, c_out, TDO);
endinterface

// File: rtl/asic_with_tap_ctrl.sv
// 16-state TAP controller: state register plus decoded per-state strobes.
`timescale 1ns/1ps
module tap_controller
  import asic_tap_pkg::*;
(
  input  logic TCK,
  input  logic TRSTn,
  input  logic TMS,
  output logic tlr,
  output logic cap_dr,
  output logic sh_dr,
  output logic upd_dr,
  output logic cap_ir,
  output logic sh_ir,
  output logic upd_ir
);

  tap_state_t state_q, state_d;

  // State register, forced to Test-Logic-Reset by TRSTn.
  always_ff @(posedge TCK or negedge TRSTn) begin
    if (!TRSTn) state_q <= TLR;
    else        state_q <= state_d;
  end

  // Next-state graph driven by TMS, and the strobes decoded from the current state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TLR:    state_d = TMS ? TLR    : RTI;
      RTI:    state_d = TMS ? SEL_DR : RTI;
      SEL_DR: state_d = TMS ? SEL_IR : CAP_DR;
      CAP_DR: state_d = TMS ? EX1_DR : SH_DR;
      SH_DR:  state_d = TMS ? EX1_DR : SH_DR;
      EX1_DR: state_d = TMS ? UPD_DR : PA_DR;
      PA_DR:  state_d = TMS ? EX2_DR : PA_DR;
      EX2_DR: state_d = TMS ? UPD_DR : SH_DR;
      UPD_DR: state_d = TMS ? SEL_DR : RTI;
      SEL_IR: state_d = TMS ? TLR    : CAP_IR;
      CAP_IR: state_d = TMS ? EX1_IR : SH_IR;
      SH_IR:  state_d = TMS ? EX1_IR : SH_IR;
      EX1_IR: state_d = TMS ? UPD_IR : PA_IR;
      PA_IR:  state_d = TMS ? EX2_IR : PA_IR;
      EX2_IR: state_d = TMS ? UPD_IR : SH_IR;
      UPD_IR: state_d = TMS ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
    tlr    = (state_q == TLR);
    cap_dr = (state_q == CAP_DR);
    sh_dr  = (state_q == SH_DR);
    upd_dr = (state_q == UPD_DR);
    cap_ir = (state_q == CAP_IR);
    sh_ir  = (state_q == SH_IR);
    upd_ir = (state_q == UPD_IR);
  end

endmodule

// File: rtl/asic_with_tap.sv
// Top level: ripple-carry adder core behind an IEEE 1149.1-style TAP with
// IR, bypass and boundary-scan registers.
// Optional build macro TDO_TRISTATE_EN: TDO floats outside Shift-DR/Shift-IR.
`timescale 1ns/1ps
module asic_with_tap
  import asic_tap_pkg::*;
#(
  parameter int unsigned SIZE     = DEF_SIZE,
  parameter int unsigned BSR_SIZE = DEF_BSR_SIZE,
  parameter int unsigned IR_SIZE  = DEF_IR_SIZE
)
(
  input logic            TCK,
  input logic            TRSTn,
  asic_with_tap_if.slave bus
);

  logic tlr, cap_dr, sh_dr, upd_dr, cap_ir, sh_ir, upd_ir;

  logic [IR_SIZE-1:0]  ir_sh, ir_upd;
  logic                byp;
  logic [BSR_SIZE-1:0] bsr_sh, bsr_upd, bsr_cap;
  logic                tdo_q;
  logic                bsr_sel, intest, extest;

  logic [SIZE-1:0] core_a, core_b, core_sum;
  logic            core_cin, core_cout;

  tap_controller u_ctrl (
    .TCK    (TCK),
    .TRSTn  (TRSTn),
    .TMS    (bus.TMS),
    .tlr    (tlr),
    .cap_dr (cap_dr),
    .sh_dr  (sh_dr),
    .upd_dr (upd_dr),
    .cap_ir (cap_ir),
    .sh_ir  (sh_ir),
    .upd_ir (upd_ir)
  );

  assign bsr_sel = selects_bsr(ir_upd);
  assign intest  = (ir_upd == OP_INTEST);
  assign extest  = (ir_upd == OP_EXTEST);

  // Boundary net on the input side: INTEST feeds the core from the BSR update stage.
  always_comb begin
    {core_a, core_b, core_cin} = {bus.a, bus.b, bus.c_in};
    if (intest) {core_a, core_b, core_cin} = bsr_upd[2*SIZE:0];
  end

  // Ripple-carry adder core.
  always_comb begin
    logic [SIZE:0] carry;
    carry    = '0;
    core_sum = '0;
    carry[0] = core_cin;
    for (int unsigned i = 0; i < SIZE; i++) begin
      core_sum[i]  = core_a[i] ^ core_b[i] ^ carry[i];
      carry[i+1]   = (core_a[i] & core_b[i]) | (carry[i] & (core_a[i] ^ core_b[i]));
    end
    core_cout = carry[SIZE];
  end

  // Boundary net on the output side: EXTEST drives the pads from the BSR update stage.
  assign bus.sum   = extest ? bsr_upd[BSR_SIZE-1 -: SIZE] : core_sum;
  assign bus.c_out = extest ? bsr_upd[2*SIZE+1]           : core_cout;

  assign bsr_cap = {core_sum, core_cout, core_a, core_b, core_cin};

  // IR shift stage: reload BYPASS in TLR, capture 001, shift toward TDO.
  always_ff @(posedge TCK or negedge TRSTn) begin
    if (!TRSTn)      ir_sh <= OP_BYPASS;
    else if (tlr)    ir_sh <= OP_BYPASS;
    else if (cap_ir) ir_sh <= IR_CAPTURE;
    else if (sh_ir)  ir_sh <= {bus.TDI, ir_sh[IR_SIZE-1:1]};
  end

  // IR update latch: new instruction takes effect on the Update-IR falling edge.
  always_ff @(negedge TCK or negedge TRSTn) begin
    if (!TRSTn)      ir_upd <= OP_BYPASS;
    else if (tlr)    ir_upd <= OP_BYPASS;
    else if (upd_ir) ir_upd <= ir_sh;
  end

  // Bypass register: cleared on capture, one-bit TDI delay while shifting.
  always_ff @(posedge TCK or negedge TRSTn) begin
    if (!TRSTn)                 byp <= 1'b0;
    else if (cap_dr)            byp <= 1'b0;
    else if (sh_dr && !bsr_sel) byp <= bus.TDI;
  end

  // BSR shift stage: captures core/boundary values, shifts toward TDO.
  always_ff @(posedge TCK or negedge TRSTn) begin
    if (!TRSTn)                 bsr_sh <= '0;
    else if (cap_dr && bsr_sel) bsr_sh <= bsr_cap;
    else if (sh_dr && bsr_sel)  bsr_sh <= {bus.TDI, bsr_sh[BSR_SIZE-1:1]};
  end

  // BSR update stage: loaded from the shift stage on the Update-DR falling edge.
  always_ff @(negedge TCK or negedge TRSTn) begin
    if (!TRSTn)                 bsr_upd <= '0;
    else if (upd_dr && bsr_sel) bsr_upd <= bsr_sh;
  end

  // TDO register: follows the selected register's bit 0 while shifting, else holds.
  always_ff @(negedge TCK or negedge TRSTn) begin
    if (!TRSTn)     tdo_q <= 1'b0;
    else if (sh_dr) tdo_q <= bsr_sel ? bsr_sh[0] : byp;
    else if (sh_ir) tdo_q <= ir_sh[0];
  end

`ifdef TDO_TRISTATE_EN
  assign bus.TDO = (sh_dr || sh_ir) ? tdo_q : 1'bz;
`else
  assign bus.TDO = tdo_q;
`endif

endmodule

// File: tb/tb_asic_with_tap.sv
// Directed bench for asic_with_tap: JTAG sequences driven from tasks, a
// register-level model of what each scan must shift out and what the pads
// must show, and one compare process checking both every TCK.
`timescale 1ns/1ps
module tb_asic_with_tap;

  logic TCK = 1'b0;
  logic TRSTn;

  asic_with_tap_if #(.SIZE(4)) bus ();

  asic_with_tap #(.SIZE(4), .BSR_SIZE(14), .IR_SIZE(3)) dut (
    .TCK   (TCK),
    .TRSTn (TRSTn),
    .bus   (bus)
  );

  always #5 TCK = ~TCK;

  int total = 0;
  int bad   = 0;

  logic        sh_chk  = 1'b0;
  logic        exp_tdo = 1'b0;
  logic        pad_chk = 1'b0;
  logic [2:0]  m_ir    = 3'b111;
  logic [13:0] m_bsr   = '0;
  logic [31:0] obs     = '0;
  int          obs_n   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: effective core inputs {a,b,c_in}
  function automatic logic [8:0] m_core_in();
    return (m_ir == 3'b011) ? m_bsr[8:0] : {bus.a, bus.b, bus.c_in};
  endfunction

  // Model: {carry, sum} from plain addition
  function automatic logic [4:0] m_core_out();
    logic [8:0] x;
    x = m_core_in();
    return {1'b0, x[8:5]} + {1'b0, x[4:1]} + {4'b0, x[0]};
  endfunction

  // Model: {sum, c_out} at the pads
  function automatic logic [4:0] m_pads();
    logic [4:0] r;
    r = m_core_out();
    return (m_ir == 3'b001) ? m_bsr[13:9] : {r[3:0], r[4]};
  endfunction

  function automatic logic [13:0] m_cap();
    logic [4:0] r;
    r = m_core_out();
    return {r[3:0], r[4], m_core_in()};
  endfunction

  function automatic logic m_bsr_sel();
    return m_ir inside {3'b001, 3'b010, 3'b011};
  endfunction

  always @(posedge TCK) begin
    #1;
    if (sh_chk) begin
      check("tdo", {31'b0, bus.TDO}, {31'b0, exp_tdo});
      obs[obs_n] = bus.TDO;
      obs_n++;
    end
    if (pad_chk) check("pads", {27'b0, bus.sum, bus.c_out}, {27'b0, m_pads()});
  end

  task automatic step(input logic tms, input logic tdi, input logic chk, input logic e);
    @(negedge TCK);
    #2;
    bus.TMS = tms;
    bus.TDI = tdi;
    sh_chk  = chk;
    exp_tdo = e;
  endtask

  // Full scan from Run-Idle back to Run-Idle; optional pause after bit 'split'.
  task automatic scan(input logic ir, input int n, input logic [31:0] din,
                      input int split, input int pause);
    logic [31:0] e;
    logic        bsr_path;
    bsr_path = m_bsr_sel();
    if (ir)            e = {din[28:0], 3'b001};
    else if (bsr_path) e = {din[17:0], m_cap()};
    else               e = {din[30:0], 1'b0};
    step(1'b1, 1'b0, 1'b0, 1'b0);
    if (ir) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    obs   = '0;
    obs_n = 0;
    for (int i = 0; i < n; i++) begin
      step((i == n-1) || (i == split-1), din[i], 1'b1, e[i]);
      if (i == split-1) begin
        for (int p = 0; p < pause; p++) step(1'b0, 1'b0, 1'b0, 1'b0);
        if (pause > 0) step(1'b1, 1'b0, 1'b0, 1'b0);
        if (i != n-1)  step(1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    if (ir)            m_ir  = din[2:0];
    else if (bsr_path) m_bsr = 14'(din >> (n-14));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: no finish by %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [13:0] cap;
    TRSTn    = 1'b0;
    bus.TMS  = 1'b1;
    bus.TDI  = 1'b0;
    bus.a    = 4'hA;
    bus.b    = 4'h5;
    bus.c_in = 1'b0;
    #23;
    TRSTn = 1'b1;
    #3;
    check("reset_tdo", {31'b0, bus.TDO}, 32'd0);
    check("reset_sum", {28'b0, bus.sum}, 32'hF);
    check("reset_cout", {31'b0, bus.c_out}, 32'd0);
    pad_chk = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // default bypass path
    scan(1'b0, 10, 32'b1010011100, 10, 0);
    check("bypass_stream", obs, 32'b0100111000);

    // INTEST load with pause
    scan(1'b1, 3, 32'b011, 3, 4);
    check("ir_stream", obs, 32'b001);
    check("intest_zero_sum", {27'b0, bus.sum, bus.c_out}, 32'd0);

    // INTEST scan split by a pause and resumed from Exit2
    scan(1'b0, 14, 32'b01001101010100, 7, 3);
    check("intest_sum", {28'b0, bus.sum}, 32'h4);
    check("intest_cout", {31'b0, bus.c_out}, 32'd1);

    scan(1'b0, 14, 32'h3FFF, 14, 0);
    check("intest_capture", obs, 32'b01001101010100);
    check("intest_ff_sum", {27'b0, bus.sum, bus.c_out}, 32'b11111);

    // IDCODE behaves as bypass
    scan(1'b1, 3, 32'b101, 3, 0);
    scan(1'b0, 5, 32'b10110, 5, 0);
    check("idcode_stream", obs, 32'b01100);
    check("idcode_pads", {27'b0, bus.sum, bus.c_out}, 32'b11110);

    // EXTEST
    scan(1'b1, 3, 32'b001, 3, 0);
    scan(1'b0, 14, {18'b0, 4'h6, 1'b1, 9'h0}, 14, 0);
    check("extest_capture", obs, 32'b11110101001010);
    check("extest_pads", {27'b0, bus.sum, bus.c_out}, 32'b01101);

    // TMS reset from Shift-DR (passes Update-DR with one bit shifted)
    cap = m_cap();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    pad_chk = 1'b0;
    for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
    m_ir    = 3'b111;
    m_bsr   = {1'b0, cap[13:1]};
    pad_chk = 1'b1;
    @(posedge TCK);
    #2;
    check("tms_reset_pads", {27'b0, bus.sum, bus.c_out}, 32'b11110);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Async reset in the middle of an IR shift
    scan(1'b1, 3, 32'b001, 3, 0);
    scan(1'b0, 14, {18'b0, 4'h9, 1'b0, 9'h1FF}, 14, 0);
    check("extest2_pads", {27'b0, bus.sum, bus.c_out}, 32'b10010);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge TCK);
    #2;
    sh_chk = 1'b0;
    @(negedge TCK);
    #2;
    check("pre_reset_tdo", {31'b0, bus.TDO}, 32'd1);
    TRSTn = 1'b0;
    #1;
    m_ir  = 3'b111;
    m_bsr = '0;
    check("async_tdo", {31'b0, bus.TDO}, 32'd0);
    check("async_pads", {27'b0, bus.sum, bus.c_out}, 32'b11110);
    #10;
    TRSTn = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    bus.a    = 4'h3;
    bus.b    = 4'h4;
    bus.c_in = 1'b1;
    scan(1'b0, 4, 32'b1101, 4, 0);
    check("post_reset_bypass", obs, 32'b1010);
    check("post_reset_pads", {27'b0, bus.sum, bus.c_out}, 32'b10000);

    pad_chk = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/asic_with_tap.md
Name: asic_with_tap

Overview:
- 4-bit ripple-carry adder core (sum, c_out = a + b + c_in) wrapped in an IEEE 1149.1-style test access port (TAP).
- TAP contains a 16-state controller, a 3-bit instruction register (IR), a 1-bit bypass register and a 14-bit boundary-scan register (BSR).
- Top-level chip block; the board/bench drives TDI, TMS and TCK and observes TDO.

Parameters:
- SIZE, 4, adder operand width.
- BSR_SIZE, 14, boundary-scan length (2*SIZE+1 inputs + SIZE+1 outputs).
- IR_SIZE, 3, instruction register width.

Ports:
- TCK input 1: test clock; the only clock.
- TRSTn input 1: asynchronous active-low TAP reset.
- a input SIZE: operand A pad.
- b input SIZE: operand B pad.
- c_in input 1: carry-in pad.
- sum output SIZE: sum pad.
- c_out output 1: carry-out pad.
- TDI input 1: serial test data in.
- TMS input 1: test mode select, sampled on posedge TCK.
- TDO output 1: serial test data out.

Behaviour:
- Reset (TRSTn=0, async):
  - Controller enters Test-Logic-Reset (TLR); IR and IR update latch = BYPASS (111).
  - Bypass register = 0; BSR shift and update stages = 0; TDO = 0.
- Controller:
  - State advances on posedge TCK from TMS; standard graph: TLR, Run-Idle, Select-DR, Capture-DR, Shift-DR, Exit1-DR, Pause-DR, Exit2-DR, Update-DR, plus the six IR equivalents.
  - TMS=1 for 5 consecutive posedges from any state reaches TLR; entering TLR reloads BYPASS.
  - Shift loops on TMS=0. Pause holds the register contents unchanged for any duration. Exit2 with TMS=0 resumes Shift.
- Opcodes:
  - BYPASS 111, EXTEST 001, SAMPLE_PRELOAD 010, INTEST 011, RUNBIST 100, IDCODE 101.
  - RUNBIST, IDCODE and any undefined code behave as BYPASS.
- DR selection: BSR for EXTEST, SAMPLE_PRELOAD and INTEST; bypass register otherwise.
- Capture-DR (posedge):
  - Bypass register loads 0.
  - BSR loads {sum_core[3:0], c_out_core, a, b, c_in}: bits 13:10, 9, 8:5, 4:1, 0.
- Capture-IR (posedge): IR shift stage loads 3'b001.
- Shift (posedge): TDI enters the MSB; register shifts right; bit 0 feeds TDO. Bench must present c_in (bit 0) first.
- TDO: updated on negedge TCK with the selected register's bit 0 while in Shift-DR or Shift-IR; otherwise holds its last value. Bypass path gives a 1-TCK delay, TDI to TDO.
- Update-DR / Update-IR: the update stage loads from the shift stage on negedge TCK while in the Update state. A new instruction takes effect from that negedge.
- Boundary net (internal, 14 bits):
  - INTEST: core inputs a/b/c_in are taken from BSR update bits 8:0.
  - EXTEST: output pads sum/c_out are driven from BSR update bits 13:9.
  - All other instructions (including BYPASS): a/b/c_in pass straight to the core and core outputs pass straight to the pads.
- Core: combinational; width SIZE+1 result, with c_out as the MSB.

Optional Feature:
- TDO_TRISTATE_EN:
  - Defined: TDO is 1'bz whenever the controller is not in Shift-DR or Shift-IR, driven otherwise.
  - Undefined: TDO is always driven, with the hold behaviour above.

Decomposition:
- Package asic_tap_pkg:
  - TAP state enum (16 states).
  - IR opcode constants.
  - SIZE/BSR_SIZE/IR_SIZE defaults.
  - IR capture constant 3'b001.
- One sub-module, tap_controller: FSM plus decoded strobes (capture/shift/update for DR and IR, reset).
- Top level holds the registers and the adder.

Test Plan:
- Functional core: after reset with a=4'hA, b=4'h5, c_in=0 -> sum=4'hF, c_out=0 (BYPASS is transparent).
- Default bypass: after TRSTn pulse, go Select-DR -> Capture-DR -> Shift-DR and shift 10 bits 1010011100 -> TDO replays the same bits one TCK later, first bit 0. IR stays 111.
- IR load with pause: shift 3'b011 (LSB first) via Shift-IR, pause 4 cycles, Exit2 -> Update-IR -> TDO during shift shows 1,0,0; instruction = INTEST.
- INTEST scan: scan 14'b0100_1_1010_1010_0, pause, update -> core sees a=A, b=A, c_in=0. Next DR scan of 14'h3FFF shifts out 0100_1_1010_1010_0 (captured sum=4, c_out=1, bit 0 first).
- TMS reset: from Shift-DR, hold TMS=1 for 5 TCKs -> TLR, IR=111, boundary net transparent.
- Async reset mid-shift: drop TRSTn during Shift-IR -> immediate TLR, IR=111, TDO=0; no partial update is applied.
